// File: rtl/belt_mp.sv
// Multi-port belt: circular operand store with dual drop, flush, live count and fall-off reporting.
// Optional same-cycle read forwarding is enabled by defining BELT_FWD_EN.
module belt_mp #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 16,
  parameter int IDXW  = 4,
  parameter int NREAD = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   drop_a,
  input  logic [WIDTH-1:0]       drop_a_data,
  input  logic                   drop_b,
  input  logic [WIDTH-1:0]       drop_b_data,
  input  logic                   flush,
  input  logic [NREAD*IDXW-1:0]  rpos,
  output logic [NREAD*WIDTH-1:0] rdata,
  output logic [NREAD-1:0]       rmiss,
  output logic [IDXW:0]          count,
  output logic [1:0]             fall_valid,
  output logic [2*WIDTH-1:0]     fall_data
);

  localparam logic [IDXW+1:0] DEPTH_W = (IDXW+2)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];

  logic [IDXW-1:0]  idx_reg, idx_next;
  logic [IDXW:0]    count_reg, count_next;
  logic [1:0]       ndrop;
  logic [IDXW+1:0]  sum;
  logic [1:0]       nfall;
  logic [IDXW-1:0]  wa_b, fa0, fa1;
  logic [1:0]       fall_valid_reg;
  logic [WIDTH-1:0] fall0_reg, fall1_reg;

  assign ndrop    = {1'b0, drop_a} + {1'b0, drop_b};
  assign sum      = {1'b0, count_reg} + {{IDXW{1'b0}}, ndrop};
  assign idx_next = idx_reg + IDXW'(ndrop);
  assign wa_b     = drop_a ? idx_reg + IDXW'(1) : idx_reg;

  always_comb begin
    nfall      = 2'd0;
    count_next = sum[IDXW:0];
    if (sum > DEPTH_W) begin
      count_next = DEPTH_W[IDXW:0];
      if (!flush) nfall = 2'(sum - DEPTH_W);
    end
    if (flush) count_next = {{(IDXW-1){1'b0}}, ndrop};
  end

  // Falling entries are the last nfall slots written this cycle; slot 0 is the older one.
  assign fa0 = idx_reg + IDXW'(ndrop) - IDXW'(nfall);
  assign fa1 = fa0 + IDXW'(1);

  always_ff @(posedge clk) begin
    if (!rst) begin
      if (drop_a) mem[idx_reg] <= drop_a_data;
      if (drop_b) mem[wa_b]    <= drop_b_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      idx_reg        <= '0;
      count_reg      <= '0;
      fall_valid_reg <= 2'b00;
      fall0_reg      <= '0;
      fall1_reg      <= '0;
    end else begin
      idx_reg        <= idx_next;
      count_reg      <= count_next;
      fall_valid_reg <= {nfall == 2'd2, nfall != 2'd0};
      fall0_reg      <= (nfall != 2'd0) ? mem[fa0] : '0;
      fall1_reg      <= (nfall == 2'd2) ? mem[fa1] : '0;
    end
  end

  assign count      = count_reg;
  assign fall_valid = fall_valid_reg;
  assign fall_data  = {fall1_reg, fall0_reg};

  genvar gi;
  generate
    for (gi = 0; gi < NREAD; gi++) begin : g_rd
      logic [IDXW-1:0]  pos;
      logic             miss;
      logic [WIDTH-1:0] data;
      logic             miss_reg;
      logic [WIDTH-1:0] data_reg;

      assign pos = rpos[gi*IDXW +: IDXW];

`ifdef BELT_FWD_EN
      // Positions below ndrop are this cycle's drops; the newest is drop_b when both fire.
      always_comb begin
        miss = ({1'b0, pos} >= count_next);
        data = mem[idx_next - IDXW'(1) - pos];
        if (pos < IDXW'(ndrop)) begin
          if (ndrop == 2'd2) data = (pos == '0) ? drop_b_data : drop_a_data;
          else               data = drop_b ? drop_b_data : drop_a_data;
        end
      end
`else
      assign miss = ({1'b0, pos} >= count_reg);
      assign data = mem[idx_reg - IDXW'(1) - pos];
`endif

      always_ff @(posedge clk) begin
        if (rst) begin
          miss_reg <= 1'b0;
          data_reg <= '0;
        end else begin
          miss_reg <= miss;
          data_reg <= miss ? '0 : data;
        end
      end

      assign rmiss[gi]                 = miss_reg;
      assign rdata[gi*WIDTH +: WIDTH]  = data_reg;
    end
  endgenerate

endmodule

// File: tb/tb_belt_mp.sv
// Directed, table-driven bench for belt_mp (default parameters, two read ports).
module tb_belt_mp;

  logic        clk = 1'b0;
  logic        rst;
  logic        drop_a, drop_b, flush;
  logic [31:0] drop_a_data, drop_b_data;
  logic [7:0]  rpos;
  logic [63:0] rdata;
  logic [1:0]  rmiss;
  logic [4:0]  count;
  logic [1:0]  fall_valid;
  logic [63:0] fall_data;

  int checks = 0;
  int errors = 0;

  belt_mp dut (
    .clk(clk), .rst(rst),
    .drop_a(drop_a), .drop_a_data(drop_a_data),
    .drop_b(drop_b), .drop_b_data(drop_b_data),
    .flush(flush), .rpos(rpos),
    .rdata(rdata), .rmiss(rmiss), .count(count),
    .fall_valid(fall_valid), .fall_data(fall_data)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        da;
    logic [31:0] ad;
    logic        db;
    logic [31:0] bd;
    logic        fl;
    logic [3:0]  p0, p1;
    logic        chk_rd;
    logic [31:0] r0, r1;
    logic [1:0]  miss;
    logic [4:0]  cnt;
    logic [1:0]  fv;
    logic [31:0] f0, f1;
  } vec_t;

  vec_t vecs[128];
  int   nv = 0;

  task automatic add(input logic da, input logic [31:0] ad, input logic db, input logic [31:0] bd,
                     input logic fl, input logic [3:0] p0, input logic [3:0] p1, input logic chk_rd,
                     input logic [31:0] r0, input logic [31:0] r1, input logic [1:0] miss,
                     input logic [4:0] cnt, input logic [1:0] fv, input logic [31:0] f0,
                     input logic [31:0] f1);
    vecs[nv] = '{da, ad, db, bd, fl, p0, p1, chk_rd, r0, r1, miss, cnt, fv, f0, f1};
    nv++;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic da, input logic [31:0] ad, input logic db, input logic [31:0] bd,
                       input logic fl, input logic [3:0] p0, input logic [3:0] p1);
    drop_a = da; drop_a_data = ad; drop_b = db; drop_b_data = bd;
    flush = fl; rpos = {p1, p0};
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1;
    drive(0, 0, 0, 0, 0, 0, 0);
    drive(0, 0, 0, 0, 0, 0, 0);
    chk("reset_count", 32'(count), 0);
    chk("reset_fv", 32'(fall_valid), 0);
    chk("reset_rmiss", 32'(rmiss), 0);
    chk("reset_rdata0", rdata[31:0], 0);
    rst = 1'b0;

    // da ad db bd fl p0 p1 chk r0 r1 miss cnt fv f0 f1
    add(1, 32'h11, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0);
    add(1, 32'h22, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2, 0, 0, 0);
    add(1, 32'h33, 0, 0, 0, 0, 0, 0, 0, 0, 0, 3, 0, 0, 0);
    add(0, 0, 0, 0, 0, 0, 2, 1, 32'h33, 32'h11, 2'b00, 3, 0, 0, 0);
    add(0, 0, 0, 0, 0, 3, 0, 1, 0, 32'h33, 2'b01, 3, 0, 0, 0);
    add(0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    add(1, 32'hA, 1, 32'hB, 0, 0, 0, 0, 0, 0, 0, 2, 0, 0, 0);
    add(0, 0, 0, 0, 0, 0, 1, 1, 32'hB, 32'hA, 2'b00, 2, 0, 0, 0);
    add(0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    for (int i = 1; i <= 16; i++) add(1, 32'(i), 0, 0, 0, 0, 0, 0, 0, 0, 0, 5'(i), 0, 0, 0);
    add(1, 32'h100, 1, 32'h101, 0, 0, 0, 0, 0, 0, 0, 16, 2'b11, 32'd1, 32'd2);
    add(0, 0, 0, 0, 0, 0, 15, 1, 32'h101, 32'd3, 2'b00, 16, 0, 0, 0);
    add(0, 0, 1, 32'h200, 0, 0, 0, 0, 0, 0, 0, 16, 2'b01, 32'd3, 0);
    add(0, 0, 0, 0, 0, 0, 1, 1, 32'h200, 32'h101, 2'b00, 16, 0, 0, 0);
    // Count 15 plus a dual drop: exactly one (the oldest) entry falls.
    add(0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 7; i++)
      add(1, 32'h300 + 32'(2*i), 1, 32'h301 + 32'(2*i), 0, 0, 0, 0, 0, 0, 0, 5'(2*i+2), 0, 0, 0);
    add(1, 32'h30E, 0, 0, 0, 0, 0, 0, 0, 0, 0, 15, 0, 0, 0);
    add(1, 32'h400, 1, 32'h401, 0, 0, 0, 0, 0, 0, 0, 16, 2'b01, 32'h300, 0);
    add(0, 0, 0, 0, 0, 0, 15, 1, 32'h401, 32'h301, 2'b00, 16, 0, 0, 0);
    // Flush together with a drop at count 9.
    add(0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 9; i++) add(1, 32'h500 + 32'(i), 0, 0, 0, 0, 0, 0, 0, 0, 0, 5'(i+1), 0, 0, 0);
    add(1, 32'h55, 0, 0, 1, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0);
    add(0, 0, 0, 0, 0, 0, 1, 1, 32'h55, 0, 2'b10, 1, 0, 0, 0);
`ifdef BELT_FWD_EN
    add(1, 32'h77, 0, 0, 0, 0, 1, 1, 32'h77, 32'h55, 2'b00, 2, 0, 0, 0);
`else
    add(1, 32'h77, 0, 0, 0, 0, 1, 1, 32'h55, 0, 2'b10, 2, 0, 0, 0);
`endif
    add(0, 0, 0, 0, 0, 0, 1, 1, 32'h77, 32'h55, 2'b00, 2, 0, 0, 0);

    for (int v = 0; v < nv; v++) begin
      drive(vecs[v].da, vecs[v].ad, vecs[v].db, vecs[v].bd, vecs[v].fl, vecs[v].p0, vecs[v].p1);
      $display("vec %0d: count=%0d fv=%b rmiss=%b rdata0=%h rdata1=%h", v, count, fall_valid,
               rmiss, rdata[31:0], rdata[63:32]);
      chk($sformatf("v%0d_count", v), 32'(count), 32'(vecs[v].cnt));
      chk($sformatf("v%0d_fall_valid", v), 32'(fall_valid), 32'(vecs[v].fv));
      if (vecs[v].fv[0]) chk($sformatf("v%0d_fall0", v), fall_data[31:0], vecs[v].f0);
      if (vecs[v].fv[1]) chk($sformatf("v%0d_fall1", v), fall_data[63:32], vecs[v].f1);
      if (vecs[v].chk_rd) begin
        chk($sformatf("v%0d_rmiss", v), 32'(rmiss), 32'(vecs[v].miss));
        chk($sformatf("v%0d_rdata0", v), rdata[31:0], vecs[v].r0);
        chk($sformatf("v%0d_rdata1", v), rdata[63:32], vecs[v].r1);
      end
    end

    // Mid-stream reset at count 10 (count is 2 here).
    for (int i = 0; i < 8; i++) drive(1, 32'h600 + 32'(i), 0, 0, 0, 0, 0);
    chk("pre_rst_count", 32'(count), 10);
    rst = 1'b1;
    drive(1, 32'h6FF, 0, 0, 0, 0, 1);
    rst = 1'b0;
    $display("rst: count=%0d fv=%b", count, fall_valid);
    chk("rst_count", 32'(count), 0);
    chk("rst_fall_valid", 32'(fall_valid), 0);
    drive(0, 0, 0, 0, 0, 0, 1);
    $display("post-rst read: rmiss=%b rdata0=%h rdata1=%h", rmiss, rdata[31:0], rdata[63:32]);
    chk("post_rst_rmiss", 32'(rmiss), 32'h3);
    chk("post_rst_rdata0", rdata[31:0], 0);
    chk("post_rst_rdata1", rdata[63:32], 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/belt_mp.md
Name: belt_mp

Overview:
- Parametrised multi-port belt (FIFO-addressed operand store) for the next-generation core.
- Generalises the single-drop, two-read, 16x32 belt with the following:
  - configurable width, depth and read-port count
  - dual drop per cycle
  - live-entry tracking
  - flush
  - a fall-off (spill) output that reports values pushed off the oldest end.
- Sits between the core's issue/writeback logic and a future spill engine.

Parameters:
- WIDTH, 32, data width of each belt entry.
- DEPTH, 16, number of entries; power of two, >= 4.
- IDXW, 4, position/index width; must equal log2(DEPTH).
- NREAD, 2, number of read ports, 1..4.

Ports:
- clk  in  1  clock.
- rst  in  1  reset.
- drop_a  in  1  push drop_a_data this cycle (older of the pair).
- drop_a_data  in  WIDTH  data for drop_a.
- drop_b  in  1  push drop_b_data this cycle (newer of the pair).
- drop_b_data  in  WIDTH  data for drop_b.
- flush  in  1  invalidate all live entries.
- rpos  in  NREAD*IDXW  packed belt positions; port k uses bits [k*IDXW +: IDXW]; 0 = newest.
- rdata  out  NREAD*WIDTH  packed registered read data.
- rmiss  out  NREAD  registered; position k was not live (rdata forced 0).
- count  out  IDXW+1  live entries, 0..DEPTH.
- fall_valid  out  2  registered; bit i set when one entry fell off the oldest end.
- fall_data  out  2*WIDTH  registered fallen values; slot 0 = older.

Behaviour:
- Reset:
  - rst is synchronous and active-high; clock is clk.
  - Reset clears head index, count, rdata, rmiss, fall_valid and fall_data to 0.
  - Storage RAM is not reset.
- Storage:
  - Circular array of DEPTH entries with write pointer idx.
  - Position p maps to entry (idx-1-p) mod DEPTH. Indices wrap modulo DEPTH with no special casing.
- Drops:
  - ndrop = drop_a + drop_b.
  - drop_a only: writes entry idx; idx advances by 1.
  - drop_b only: writes entry idx; idx advances by 1.
  - Both: drop_a_data goes to idx, drop_b_data to idx+1; idx advances by 2, so drop_b_data becomes position 0 and drop_a_data position 1.
- Count:
  - Normal update is count_next = min(count+ndrop, DEPTH).
  - flush in the same cycle as drops: flush is applied first, so count_next = ndrop and the drops still land.
  - flush alone: count goes to 0; idx is unchanged.
- Fall-off (visible the cycle after the drop):
  - The number of entries falling is max(0, count+ndrop-DEPTH), evaluated before flush; with flush asserted, nothing falls.
  - For each falling entry, the overwritten old value appears in fall_data; the older one is in slot 0.
  - fall_valid bits are packed from bit 0 and pulse for exactly one cycle.
- Reads:
  - 1-cycle latency: rdata and rmiss are registered from rpos sampled at the edge.
  - Reads reflect belt state before the same cycle's drops/flush.
  - rmiss[k] = (rpos[k] >= count); when set, rdata[k] = 0.
  - Ports are independent; identical positions on several ports are legal.
- Invariants:
  - count never exceeds DEPTH.
  - With no drop and no flush, state holds and fall_valid = 0.

Optional Feature:
- Macro BELT_FWD_EN.
- When defined:
  - Reads see post-drop/post-flush state of the same cycle: position 0 returns the newest dropped value, position 1 the next, and so on.
  - rmiss uses count_next.
  - Implemented as a forwarding mux in front of the read registers; latency stays 1 cycle.
- When undefined: pre-drop semantics as above, with no forwarding logic.

Test Plan:
- Reset, then drop_a with 0x11, 0x22, 0x33 on successive cycles; read rpos={0,2} -> rdata={0x33,0x11}, rmiss=0, count=3; rpos=3 -> rmiss=1, rdata=0.
- Dual drop with a=0xA, b=0xB from empty -> next cycle count=2; pos0=0xB, pos1=0xA.
- Fill DEPTH=16 with values 1..16, then dual drop 0x100/0x101 -> fall_valid=2'b11, fall_data={slot0=1, slot1=2}, count=16, pos0=0x101.
- Flush with drop_a=0x55 in the same cycle at count=9 -> count=1, pos0=0x55, pos1 rmiss=1, fall_valid=0.
- Drop 0x77 and read pos0 in the same cycle -> pre-drop value without BELT_FWD_EN; 0x77 with BELT_FWD_EN.
- Assert rst mid-stream at count=10 -> next cycle count=0, all rmiss=1 on the subsequent read, fall_valid=0.
